// File: rtl/rv32i_prefetch.sv
// RV32I instruction prefetch queue: fetches sequential words into a small
// first-word-fall-through FIFO, flushed and restarted on redirect.
module rv32i_prefetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW:0]     count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic            run_req;
    logic            push;
    logic            pop;
    logic [1:0]      unused_pc_bits;

    assign unused_pc_bits = i_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    always_comb begin
        run_req = 1'b0;
        unique case (state_q)
            BOOT: run_req = 1'b0;
            RUN:  run_req = (count_q < FULL) && !i_redirect;
        endcase
    end

    // Reset also masks the outputs combinationally, not just at the edge.
    assign o_imem_req  = run_req && !i_rst;
    assign o_imem_addr = fetch_pc_q;
    assign o_valid     = (count_q != '0) && !i_rst;
    assign o_inst      = o_valid ? inst_mem[rd_ptr_q] : 32'h0;
    assign o_pc        = o_valid ? pc_mem[rd_ptr_q] : 32'h0;

    assign push = o_imem_req && i_imem_ack;
    assign pop  = o_valid && !i_stall;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (i_redirect) begin
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= PC_RESET;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= i_imem_data;
        end
    end

endmodule

// File: tb/tb_rv32i_prefetch.sv
// Directed bench for rv32i_prefetch; memory returns ~addr as instruction data.
module tb_rv32i_prefetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    int vecs;
    int fails;

    rv32i_prefetch #(
        .PC_RESET(32'h0000_0000),
        .DEPTH(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .o_imem_req(imem_req),
        .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack),
        .i_imem_data(imem_data),
        .i_redirect(redirect),
        .i_redirect_pc(redirect_pc),
        .i_stall(stall),
        .o_inst(inst),
        .o_pc(pc),
        .o_valid(valid)
    );

    assign imem_data = ~imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        step();
        #1;
        vecs++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_req got %b want 0", imem_req);
        end
        vecs++;
        if (valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_out got v=%b i=%h p=%h want 0/0/0", valid, inst, pc);
        end
        vecs++;
        if (imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        imem_ack = 1'b1;
        #1;
        vecs++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL boot_req got %b want 0", imem_req);
        end
        step();
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL first_req got r=%b a=%h v=%b want 1/0/0", imem_req, imem_addr, valid);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            exp_pc = 32'(k * 4);
            vecs++;
            if (valid !== 1'b1 || pc !== exp_pc || inst !== ~exp_pc) begin
                fails++;
                $display("FAIL stream_%0d got v=%b p=%h i=%h want 1/%h/%h", k, valid, pc, inst, exp_pc, ~exp_pc);
            end
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        stall = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        step();
        vecs++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin
            fails++;
            $display("FAIL full_req got r=%b a=%h want 0/00000008", imem_req, imem_addr);
        end
        step();
        vecs++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h8 || valid !== 1'b1 || pc !== 32'h0) begin
            fails++;
            $display("FAIL full_hold got r=%b a=%h v=%b p=%h want 0/8/1/0", imem_req, imem_addr, valid, pc);
        end
        stall = 1'b0;
        #1;
        vecs++;
        if (valid !== 1'b1 || pc !== 32'h0) begin
            fails++;
            $display("FAIL drain_0 got v=%b p=%h want 1/00000000", valid, pc);
        end
        step();
        vecs++;
        if (valid !== 1'b1 || pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            fails++;
            $display("FAIL drain_4 got v=%b p=%h r=%b a=%h want 1/4/1/8", valid, pc, imem_req, imem_addr);
        end
        step();
        vecs++;
        if (valid !== 1'b1 || pc !== 32'h8 || inst !== 32'hFFFF_FFF7) begin
            fails++;
            $display("FAIL drain_8 got v=%b p=%h i=%h want 1/8/fffffff7", valid, pc, inst);
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        imem_ack = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
                fails++;
                $display("FAIL wait_%0d got r=%b a=%h v=%b want 1/0/0", k, imem_req, imem_addr, valid);
            end
            step();
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        #1;
        vecs++;
        if (valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h4) begin
            fails++;
            $display("FAIL ack_push got v=%b p=%h a=%h want 1/0/4", valid, pc, imem_addr);
        end
        step();
        vecs++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL single_push got v=%b want 0", valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        stall = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        vecs++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL redir_req got %b want 0", imem_req);
        end
        step();
        redirect = 1'b0;
        #1;
        vecs++;
        if (valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL redir_next got v=%b a=%h r=%b want 0/100/1", valid, imem_addr, imem_req);
        end
        step();
        vecs++;
        if (valid !== 1'b1 || pc !== 32'h100 || inst !== 32'hFFFF_FEFF) begin
            fails++;
            $display("FAIL redir_pc got v=%b p=%h i=%h want 1/100/fffffeff", valid, pc, inst);
        end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_pc = 32'h0000_0306;
        step();
        redirect = 1'b0;
        #1;
        vecs++;
        if (imem_addr !== 32'h304 || valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_last got a=%h v=%b want 304/0", imem_addr, valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        #1;
        vecs++;
        if (imem_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pre got a=%h v=%b want fffffffc/0", imem_addr, valid);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        #1;
        vecs++;
        if (imem_addr !== 32'h0 || valid !== 1'b1 || pc !== 32'hFFFF_FFFC || inst !== 32'h3) begin
            fails++;
            $display("FAIL wrap got a=%h v=%b p=%h i=%h want 0/1/fffffffc/3", imem_addr, valid, pc, inst);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        stall = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        vecs++;
        if (valid !== 1'b0 || imem_req !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin
            fails++;
            $display("FAIL rst_comb got v=%b r=%b i=%h p=%h want 0/0/0/0", valid, imem_req, inst, pc);
        end
        step();
        rst = 1'b0;
        #1;
        vecs++;
        if (valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rst_full got v=%b r=%b a=%h want 0/0/0", valid, imem_req, imem_addr);
        end
        stall = 1'b0;
        step();
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL refetch_req got r=%b a=%h v=%b want 1/0/0", imem_req, imem_addr, valid);
        end
        step();
        vecs++;
        if (valid !== 1'b1 || pc !== 32'h0 || inst !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL refetch got v=%b p=%h i=%h want 1/0/ffffffff", valid, pc, inst);
        end
    endtask

    initial begin
        vecs = 0;
        fails = 0;
        rst = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall_full();
        test_ack_delay();
        test_redirect();
        test_wrap();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_prefetch.md
RV32I_PREFETCH -- requirements
Module: rv32i_prefetch

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the address of the first instruction fetched after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction queue entry count (legal values 2, 4, 8).
REQ-003 SHALL have port i_clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port o_imem_req  output  1  meaning instruction memory read request valid.
REQ-006 SHALL have port o_imem_addr  output  32  meaning instruction memory word address; bits [1:0] always 0.
REQ-007 SHALL have port i_imem_ack  input  1  meaning the request is accepted and i_imem_data is valid in this cycle.
REQ-008 SHALL have port i_imem_data  input  32  meaning the returned instruction word.
REQ-009 SHALL have port i_redirect  input  1  meaning branch/jump taken: flush the queue and restart fetch.
REQ-010 SHALL have port i_redirect_pc  input  32  meaning the restart address, sampled when i_redirect=1.
REQ-011 SHALL have port i_stall  input  1  meaning the downstream fetch stage cannot take an instruction this cycle.
REQ-012 SHALL have port o_inst  output  32  meaning the queue head instruction (drives the fetch stage instruction input).
REQ-013 SHALL have port o_pc  output  32  meaning the address of o_inst.
REQ-014 SHALL have port o_valid  output  1  meaning o_inst/o_pc valid (drives the fetch stage clock enable).

Function
REQ-015 SHALL implement FSM states BOOT and RUN; reset enters BOOT; BOOT -> RUN unconditionally after one cycle; RUN is left only by reset.
REQ-016 SHALL hold o_imem_req=0 in BOOT.
REQ-017 SHALL keep fetch_pc (drives o_imem_addr) and a DEPTH-entry FIFO of {pc, inst} with count 0..DEPTH.
REQ-018 SHALL in RUN drive o_imem_req = (count < DEPTH) && !i_redirect, evaluated combinationally from registered count.
REQ-019 SHALL hold o_imem_addr stable while o_imem_req=1 and i_imem_ack=0.
REQ-020 SHALL on o_imem_req && i_imem_ack push {fetch_pc, i_imem_data} and set fetch_pc <= fetch_pc + 4, wrapping mod 2^32.
REQ-021 SHALL ignore i_imem_ack when o_imem_req=0.
REQ-022 SHALL drive o_valid = (count != 0), with o_inst/o_pc from the FIFO head; zero-latency first-word-fall-through.
REQ-023 SHALL pop the head when o_valid && !i_stall.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop; FIFO pointers wrap mod DEPTH.
REQ-025 SHALL NOT push when full: the push is excluded by REQ-018 even if a pop occurs in the same cycle.
REQ-026 SHALL on i_redirect=1, with priority over push and pop, set count <= 0, reset pointers, set fetch_pc <= {i_redirect_pc[31:2], 2'b00}, and discard i_imem_data.
REQ-027 SHALL hold o_valid=0 in the cycle after a redirect, with the first post-redirect fetch requested in that cycle.
REQ-028 SHALL accept back-to-back redirects; the last one wins.
REQ-029 SHALL, when o_imem_req falls without an ack, abandon the request; the memory is required to drop it.
REQ-030 SHALL NOT affect FIFO contents or fetch_pc through i_stall.

Reset
REQ-031 SHALL while i_rst=1 force o_imem_req=0, o_valid=0, o_inst=0, o_pc=0, count=0, fetch_pc=PC_RESET, and state=BOOT.
REQ-032 SHALL, when reset is asserted mid-request or mid-stall, drop all queued and pending data at the next edge.

Verification
REQ-033 SHALL verify: reset released, memory acks every cycle, no stall -> req low 1 cycle (BOOT); o_pc sequence 0,4,8,... with o_valid continuous after first ack.
REQ-034 SHALL verify: DEPTH=2, i_stall=1 held, ack always 1 -> exactly 2 pushes (pc 0,4), then o_imem_req=0 with o_imem_addr=8; release stall -> pc 0,4,8 delivered in order.
REQ-035 SHALL verify: ack delayed 3 cycles -> o_imem_addr constant over those 3 cycles, single push on ack, o_valid=1 the next cycle.
REQ-036 SHALL verify: 2 entries queued, i_redirect=1 with i_redirect_pc=32'h0000_0103 and ack in the same cycle -> ack data discarded, o_valid=0 next cycle, next o_imem_addr=32'h0000_0100, next o_pc=32'h100.
REQ-037 SHALL verify: fetch_pc=32'hFFFF_FFFC acked -> next o_imem_addr=32'h0000_0000.
REQ-038 SHALL verify: i_rst pulsed while full and stalled -> outputs per REQ-031 next cycle; refetch restarts from PC_RESET.
